mlp_infer_ctrl: RTL and testbench
=================================

Name: mlp_infer_ctrl

Overview:
Inference sequencer and datapath sitting directly downstream of the BRAM weight/bias memory controller.
- Buffers one 784-pixel int8 image.
- Sweeps row_idx/layer_sel into the memory controller and consumes its combinational packed weight/bias outputs in the same cycle.
- Runs 32-lane layer-1 MAC, ReLU/requantize, 10-lane layer-2 MAC, then a sequential argmax.
- Reports predicted digit plus the 10 logits.

Parameters:
N_IN, 784, input pixels = layer-1 rows
N_HID, 32, hidden neurons = layer-1 lanes = layer-2 rows
N_OUT, 10, output classes
SHIFT1, 7, arithmetic right shift applied to ReLU'd layer-1 accumulators
ACC_W, 32, accumulator width (signed)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
pix_valid  in  1  pixel write strobe
pix_data  in  8  signed int8 pixel
pix_ready  out  1  high in IDLE while fewer than N_IN pixels are stored
start  in  1  begin inference (sampled in IDLE only)
layer_sel  out  2  to memory controller: 0 idle, 1 layer 1, 2 layer 2
row_idx  out  10  to memory controller: current row
w1_in_packed  in  N_HID*8  lane k = bits [k*8+:8], signed
b1_in_packed  in  N_HID*8  layer-1 biases, signed
w2_in_packed  in  N_OUT*8  layer-2 weights, signed
b2_in_packed  in  N_OUT*8  layer-2 biases, signed
busy  out  1  inference in progress
done  out  1  one-cycle pulse, result valid
digit  out  4  argmax class, held until next start
logits_packed  out  N_OUT*ACC_W  final layer-2 accumulators, lane k = [k*ACC_W+:ACC_W]

Behaviour:
- Reset (rst=1 at edge, any state):
  - state=IDLE; pixel pointer=0.
  - layer_sel=0, row_idx=0, busy=0, done=0, digit=0, logits=0.
  - Aborts any inference in progress; image buffer contents are don't-care.
- Image load (IDLE only):
  - Each pix_valid&pix_ready cycle stores pix_data at pointer, pointer++.
  - When pointer==N_IN, pix_ready=0 and further pixels are dropped.
- start:
  - Accepted only in IDLE with pointer==N_IN; otherwise ignored.
  - If start and pix_valid coincide, start wins and the pixel is dropped.
  - Acceptance cycle = T; pointer is cleared to 0 at T+1.
- States and cycle timing:
  - L1_MAC, T+1..T+784: layer_sel=1, row_idx=r (0..783). acc1[k] += pix[r]*w1[k] (signed 8x8, sign-extended to ACC_W); acc1 is cleared on entry.
  - L1_ACT, T+785: h[k] = min(127, max(0, acc1[k]+sext(b1[k])) >>> SHIFT1), unsigned 0..127 stored as int8.
  - L2_MAC, T+786..T+817: layer_sel=2, row_idx=r (0..31). acc2[j] += h[r]*w2[j].
  - L2_BIAS, T+818: acc2[j] += sext(b2[j]). The memory controller is read with layer_sel=2, row_idx=31 held; biases are row-independent.
  - ARGMAX, T+819..T+828: compares lane i=0..9, one per cycle. Strictly-greater replaces the current best, so ties resolve to the lowest index.
  - DONE, T+829: done=1, digit and logits_packed updated the same cycle; next state IDLE.
- Outputs across states:
  - busy=1 from T+1 through T+829 inclusive.
  - layer_sel=0 and row_idx=0 in IDLE and DONE.
- Arithmetic:
  - Accumulators wrap modulo 2^ACC_W with no saturation.
  - Worst case |784*128*128| < 2^31, so no overflow occurs for the defaults.
- start while busy is ignored; no queuing.

Test Plan:
- Load 784 pixels=1, all w1=1, b1=0, SHIFT1=7, w2 lane 3 =1 and others 0, b2=0, start at T:
  - h=6 (784>>>7).
  - logit3=192, others 0.
  - digit=3, done exactly at T+829, busy 829 cycles.
- ReLU/clamp check:
  - w1 lane 0 = -1 gives h0=0.
  - Lane 1 with pixels=127 and w1=127 gives h1 clamped to 127.
  - Logits match a reference model.
- Tie case:
  - All w2=0, b2 lanes 2 and 7 = 5, others 0.
  - Expect digit=2, logits[2]=logits[7]=5.
- Load handshake:
  - start after 500 pixels is ignored (busy stays 0).
  - The 785th pixel is dropped (pix_ready=0).
  - After inference, pix_ready=1 and the pointer restarts at 0.
- Reset mid-run:
  - Assert rst at T+400 for one cycle.
  - Next cycle: IDLE, busy=0, layer_sel=0, row_idx=0, no done pulse.
  - A full reload and start gives a correct result.
- Row sweep monitor:
  - row_idx increments 0..783 under layer_sel=1, then 0..31 under layer_sel=2, with no skipped or repeated rows.

Source files
------------

// File: rtl/mlp_infer_ctrl.sv
// Two-layer int8 MLP sequencer: buffers one image, sweeps weight rows from the memory controller, reports argmax + logits.
// Latency: done pulses 829 cycles after start is accepted; pix_ready drops once the buffer is full or an inference is running.
module mlp_infer_ctrl #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 32,
  parameter int N_OUT  = 10,
  parameter int SHIFT1 = 7,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  input  logic [7:0]               pix_data,
  output logic                     pix_ready,
  input  logic                     start,
  output logic [1:0]               layer_sel,
  output logic [9:0]               row_idx,
  input  logic [N_HID*8-1:0]       w1_in_packed,
  input  logic [N_HID*8-1:0]       b1_in_packed,
  input  logic [N_OUT*8-1:0]       w2_in_packed,
  input  logic [N_OUT*8-1:0]       b2_in_packed,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               digit,
  output logic [N_OUT*ACC_W-1:0]   logits_packed
);

  localparam logic [9:0] PIX_FULL = 10'(N_IN);
  localparam logic [9:0] L1_LAST  = 10'(N_IN - 1);
  localparam logic [9:0] L2_LAST  = 10'(N_HID - 1);
  localparam logic [9:0] ARG_LAST = 10'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_MAC,
    S_L1_ACT,
    S_L2_MAC,
    S_L2_BIAS,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [9:0]              ptr;
  logic [9:0]              cnt;
  logic signed [7:0]       img [N_IN];
  logic signed [ACC_W-1:0] acc1 [N_HID];
  logic signed [7:0]       h    [N_HID];
  logic signed [ACC_W-1:0] acc2 [N_OUT];
  logic signed [ACC_W-1:0] best_val;
  logic [3:0]              best_idx;

  logic       start_acc;
  logic       pix_wr;
  logic [3:0] arg_i;
  logic       arg_take;
  logic [3:0] arg_idx_nxt;

  function automatic logic signed [ACC_W-1:0] mul8(input logic signed [7:0] a,
                                                   input logic signed [7:0] b);
    logic signed [15:0] p;
    p = a * b;
    return {{(ACC_W-16){p[15]}}, p};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext8(input logic signed [7:0] a);
    return {{(ACC_W-8){a[7]}}, a};
  endfunction

  // ReLU, then requantize to 0..127 so the hidden value stays a non-negative int8
  function automatic logic signed [7:0] relu_q(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT1;
    if (v < 0)
      return 8'sd0;
    else if (s > 127)
      return 8'sd127;
    else
      return s[7:0];
  endfunction

  assign pix_ready = (state == S_IDLE) && (ptr < PIX_FULL);
  assign start_acc = (state == S_IDLE) && start && (ptr == PIX_FULL);
  assign pix_wr    = pix_valid && pix_ready && !start_acc;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Lane 0 always seeds the running best; later lanes must be strictly larger to win
  assign arg_i       = cnt[3:0];
  assign arg_take    = (cnt == 10'd0) || (acc2[arg_i] > best_val);
  assign arg_idx_nxt = arg_take ? arg_i : best_idx;

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    layer_sel = 2'd0;
    row_idx   = 10'd0;
    case (state)
      S_IDLE: begin
        if (start_acc) state_nxt = S_L1_MAC;
      end
      S_L1_MAC: begin
        layer_sel = 2'd1;
        row_idx   = cnt;
        if (cnt == L1_LAST) state_nxt = S_L1_ACT;
      end
      S_L1_ACT: begin
        layer_sel = 2'd1;
        row_idx   = L1_LAST;
        state_nxt = S_L2_MAC;
      end
      S_L2_MAC: begin
        layer_sel = 2'd2;
        row_idx   = cnt;
        if (cnt == L2_LAST) state_nxt = S_L2_BIAS;
      end
      S_L2_BIAS: begin
        layer_sel = 2'd2;
        row_idx   = L2_LAST;
        state_nxt = S_ARGMAX;
      end
      S_ARGMAX: begin
        if (cnt == ARG_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Image storage needs no reset; contents are rewritten before every inference
  always_ff @(posedge clk) begin
    if (pix_wr) img[ptr] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= 10'd0;
      cnt           <= 10'd0;
      digit         <= 4'd0;
      logits_packed <= '0;
      best_val      <= '0;
      best_idx      <= 4'd0;
      for (int k = 0; k < N_HID; k++) begin
        acc1[k] <= '0;
        h[k]    <= 8'sd0;
      end
      for (int j = 0; j < N_OUT; j++) acc2[j] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            ptr <= 10'd0;
            cnt <= 10'd0;
            for (int k = 0; k < N_HID; k++) acc1[k] <= '0;
          end else if (pix_wr) begin
            ptr <= ptr + 10'd1;
          end
        end
        S_L1_MAC: begin
          for (int k = 0; k < N_HID; k++)
            acc1[k] <= acc1[k] + mul8(img[cnt], $signed(w1_in_packed[k*8 +: 8]));
          cnt <= (cnt == L1_LAST) ? 10'd0 : cnt + 10'd1;
        end
        S_L1_ACT: begin
          for (int k = 0; k < N_HID; k++)
            h[k] <= relu_q(acc1[k] + sext8($signed(b1_in_packed[k*8 +: 8])));
          for (int j = 0; j < N_OUT; j++) acc2[j] <= '0;
          cnt <= 10'd0;
        end
        S_L2_MAC: begin
          for (int j = 0; j < N_OUT; j++)
            acc2[j] <= acc2[j] + mul8(h[cnt[4:0]], $signed(w2_in_packed[j*8 +: 8]));
          cnt <= (cnt == L2_LAST) ? 10'd0 : cnt + 10'd1;
        end
        S_L2_BIAS: begin
          for (int j = 0; j < N_OUT; j++)
            acc2[j] <= acc2[j] + sext8($signed(b2_in_packed[j*8 +: 8]));
          cnt <= 10'd0;
        end
        S_ARGMAX: begin
          if (arg_take) best_val <= acc2[arg_i];
          best_idx <= arg_idx_nxt;
          cnt      <= cnt + 10'd1;
          if (cnt == ARG_LAST) begin
            digit <= arg_idx_nxt;
            for (int j = 0; j < N_OUT; j++)
              logits_packed[j*ACC_W +: ACC_W] <= acc2[j];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Randomized and directed bench for mlp_infer_ctrl against an arithmetic reference model of the MLP.
module tb_mlp_infer_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         pix_valid;
  logic [7:0]   pix_data;
  logic         pix_ready;
  logic         start;
  logic [1:0]   layer_sel;
  logic [9:0]   row_idx;
  logic [255:0] w1_in_packed;
  logic [255:0] b1_in_packed;
  logic [79:0]  w2_in_packed;
  logic [79:0]  b2_in_packed;
  logic         busy;
  logic         done;
  logic [3:0]   digit;
  logic [319:0] logits_packed;

  always #5 clk = ~clk;

  mlp_infer_ctrl dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .start(start), .layer_sel(layer_sel), .row_idx(row_idx),
    .w1_in_packed(w1_in_packed), .b1_in_packed(b1_in_packed),
    .w2_in_packed(w2_in_packed), .b2_in_packed(b2_in_packed),
    .busy(busy), .done(done), .digit(digit), .logits_packed(logits_packed)
  );

  byte pix [784];
  byte w1  [784][32];
  byte b1  [32];
  byte w2  [32][10];
  byte b2  [10];

  int checks = 0;
  int failures = 0;
  int exp_lg [10];
  int exp_dig;
  int cap_lg [10];
  int cap_dig;

  int cyc = 0;
  int t0 = 0;
  bit mon_on = 0;
  int busy_cnt, done_cnt, done_rel, sweep_err, rdy_bad;

  // Behavioural memory controller: combinational row lookup
  always_comb begin
    w1_in_packed = '0;
    b1_in_packed = '0;
    w2_in_packed = '0;
    b2_in_packed = '0;
    for (int k = 0; k < 32; k++) begin
      w1_in_packed[k*8 +: 8] = w1[(row_idx < 10'd784) ? int'(row_idx) : 0][k];
      b1_in_packed[k*8 +: 8] = b1[k];
    end
    for (int j = 0; j < 10; j++) begin
      w2_in_packed[j*8 +: 8] = w2[int'(row_idx[4:0])][j];
      b2_in_packed[j*8 +: 8] = b2[j];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      int rel, els, erow;
      bit use_row;
      rel = cyc - t0;
      els = 0; erow = 0; use_row = 1;
      if (rel >= 1 && rel <= 784) begin els = 1; erow = rel - 1; end
      else if (rel == 785) use_row = 0;
      else if (rel >= 786 && rel <= 818) begin els = 2; erow = (rel > 817) ? 31 : rel - 786; end
      else if (rel >= 819 && rel <= 828) use_row = 0;
      if (use_row && (int'(layer_sel) != els || int'(row_idx) != erow)) sweep_err++;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_rel = rel; end
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: h = clamp(relu(sum + b1) / 128), logits = sum(h*w2) + b2, first maximum wins
  task automatic ref_model();
    int h [32];
    int acc;
    for (int k = 0; k < 32; k++) begin
      acc = b1[k];
      for (int r = 0; r < 784; r++) acc += int'(pix[r]) * int'(w1[r][k]);
      if (acc < 0) h[k] = 0;
      else h[k] = (acc / 128 > 127) ? 127 : acc / 128;
    end
    for (int j = 0; j < 10; j++) begin
      exp_lg[j] = b2[j];
      for (int r = 0; r < 32; r++) exp_lg[j] += h[r] * int'(w2[r][j]);
    end
    exp_dig = 0;
    for (int j = 1; j < 10; j++) if (exp_lg[j] > exp_lg[exp_dig]) exp_dig = j;
  endtask

  task automatic clear_mem();
    foreach (pix[i]) pix[i] = 0;
    foreach (w1[r, k]) w1[r][k] = 0;
    foreach (b1[k]) b1[k] = 0;
    foreach (w2[r, j]) w2[r][j] = 0;
    foreach (b2[j]) b2[j] = 0;
  endtask

  task automatic rand_mem();
    foreach (pix[i]) pix[i] = byte'($urandom);
    foreach (w1[r, k]) w1[r][k] = byte'($urandom);
    foreach (b1[k]) b1[k] = byte'($urandom);
    foreach (w2[r, j]) w2[r][j] = byte'($urandom);
    foreach (b2[j]) b2[j] = byte'($urandom);
  endtask

  task automatic load_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (!pix_ready) rdy_bad++;
      pix_valid = 1'b1;
      pix_data  = pix[i];
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic run_and_check(input string name);
    bit got;
    ref_model();
    busy_cnt = 0; done_cnt = 0; done_rel = -1; sweep_err = 0;
    start = 1'b1;
    t0 = cyc;
    mon_on = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 900 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        cap_dig = int'(digit);
        for (int j = 0; j < 10; j++) cap_lg[j] = $signed(logits_packed[j*32 +: 32]);
      end
    end
    chk({name, "_done_seen"}, 64'(got), 64'd1);
    repeat (3) tick();
    mon_on = 1'b0;
    chk({name, "_done_cycle"}, done_rel, 829);
    chk({name, "_busy_cycles"}, busy_cnt, 829);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_row_sweep"}, sweep_err, 0);
    chk({name, "_digit"}, cap_dig, exp_dig);
    chk({name, "_digit_hold"}, digit, exp_dig);
    for (int j = 0; j < 10; j++) chk({name, "_logit"}, cap_lg[j], exp_lg[j]);
    chk({name, "_pix_ready_after"}, pix_ready, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; pix_valid = 1'b0; pix_data = 8'd0; start = 1'b0; rdy_bad = 0;
    clear_mem();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_layer_sel", layer_sel, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_digit", digit, 0);
    chk("rst_logits", (logits_packed == '0), 1);
    chk("rst_pix_ready", pix_ready, 1);

    // All-ones image through unit weights: h = 784/128 = 6, only lane 3 sees it
    clear_mem();
    foreach (pix[i]) pix[i] = 1;
    foreach (w1[r, k]) w1[r][k] = 1;
    for (int r = 0; r < 32; r++) w2[r][3] = 1;
    load_range(0, 784);
    run_and_check("basic");
    chk("basic_logit3_abs", cap_lg[3], 192);
    chk("basic_logit0_abs", cap_lg[0], 0);
    chk("basic_digit_abs", cap_dig, 3);

    // Hidden lane 0 driven negative, lane 1 saturated; w2 routes h1->logit0, h0->logit1
    rand_mem();
    foreach (pix[i]) pix[i] = 127;
    for (int r = 0; r < 784; r++) begin w1[r][0] = -1; w1[r][1] = 127; end
    foreach (w2[r, j]) w2[r][j] = 0;
    foreach (b2[j]) b2[j] = 0;
    w2[1][0] = 1; w2[0][1] = 1;
    load_range(0, 784);
    run_and_check("clamp");
    chk("clamp_h1_sat", cap_lg[0], 127);
    chk("clamp_h0_relu", cap_lg[1], 0);

    rand_mem();
    foreach (pix[i]) pix[i] = 127;
    for (int r = 0; r < 784; r++) begin w1[r][0] = -1; w1[r][1] = 127; end
    load_range(0, 784);
    run_and_check("clamp_rand");

    // Equal maxima on lanes 2 and 7
    rand_mem();
    foreach (w2[r, j]) w2[r][j] = 0;
    foreach (b2[j]) b2[j] = 0;
    b2[2] = 5; b2[7] = 5;
    load_range(0, 784);
    run_and_check("tie");
    chk("tie_digit_abs", cap_dig, 2);
    chk("tie_logit2_abs", cap_lg[2], 5);
    chk("tie_logit7_abs", cap_lg[7], 5);

    // Premature start is ignored; overflow pixel is dropped
    rand_mem();
    load_range(0, 500);
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (busy) seen++; end
    chk("early_start_busy", seen, 0);
    tick();
    load_range(500, 784);
    chk("full_pix_ready", pix_ready, 0);
    pix_valid = 1'b1; pix_data = 8'h55;
    tick();
    pix_valid = 1'b0;
    chk("full_still_idle", busy, 0);
    run_and_check("handshake");

    // Reset at T+400 aborts cleanly
    rand_mem();
    load_range(0, 784);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (399) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_layer_sel", layer_sel, 0);
    chk("abort_row_idx", row_idx, 0);
    chk("abort_done", done, 0);
    chk("abort_digit", digit, 0);
    chk("abort_pix_ready", pix_ready, 1);
    seen = 0;
    for (int i = 0; i < 900; i++) begin @(negedge clk); if (done || busy) seen++; end
    chk("abort_no_done", seen, 0);
    tick();
    load_range(0, 784);
    run_and_check("after_abort");

    for (int n = 0; n < 3; n++) begin
      rand_mem();
      load_range(0, 784);
      run_and_check("random");
    end

    chk("load_ready", rdy_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
